rv32v_vmem_sequencer: RTL and testbench

Multi-lane vector memory sequencer for the RV32V core, sitting between the vector execute stage and the wide data-cache bus. It accepts one vector memory request of NUM_LANES elements, each with its own address, element width and mask bit. It issues the minimum number of cache-block-wide bus transactions needed to serve every enabled lane, then returns sign/zero-extended load data or a misalignment fault. It replaces the single-transaction lane path with a stateful, parametrised sequencer.

---
 rtl/rv32v_types_pkg.sv | 30 +++
 rtl/rv32v_vmem_lane_extract.sv | 42 ++++
 rtl/rv32v_vmem_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_rv32v_vmem_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V vector memory sequencer: element width,
// sequencer FSM states, default geometry and the lane alignment rule.
package rv32v_types_pkg;

  localparam int NUM_LANES_DEF   = 4;
  localparam int BLOCK_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    VW_BYTE = 2'd0,
    VW_HALF = 2'd1,
    VW_WORD = 2'd2
  } vw_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } vseq_state_e;

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic lane_misaligned(input vw_e width, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (width == VW_HALF && lo[0])       mis = 1'b1;
    if (width == VW_WORD && lo != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/rv32v_vmem_lane_extract.sv
// Per-lane load data path: picks the lane's word out of the returned cache
// block, extracts the byte/half/word at the lane's byte offset and
// sign- or zero-extends it to 32 bits.
module rv32v_vmem_lane_extract
  import rv32v_types_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int OFFW = $clog2(BLOCK_WORDS) + 2
) (
  input  logic [BLOCK_WORDS*32-1:0] blk_i,
  input  logic [OFFW-1:0]           addr_i,
  input  vw_e                       width_i,
  input  logic                      signed_i,
  output logic [31:0]               data_o
);

  logic [31:0] word;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  generate
    if (BLOCK_WORDS == 1) begin : g_one_word
      assign word = blk_i;
    end else begin : g_multi_word
      assign word = blk_i[{addr_i[OFFW-1:2], 5'b00000} +: 32];
    end
  endgenerate

  assign byte_sh = word >> {addr_i[1:0], 3'b000};
  assign half_sh = word >> {addr_i[1], 4'b0000};

  // Extend the selected element to a full register value.
  always_comb begin
    data_o = word;
    case (width_i)
      VW_BYTE: data_o = {{24{signed_i & byte_sh[7]}}, byte_sh[7:0]};
      VW_HALF: data_o = {{16{signed_i & half_sh[15]}}, half_sh[15:0]};
      default: data_o = word;
    endcase
  end

endmodule

// File: rtl/rv32v_vmem_sequencer.sv
// Multi-lane vector memory sequencer. Accepts one NUM_LANES-element request,
// checks alignment, then walks the enabled lanes issuing block-wide bus
// transactions (leader = lowest pending lane) until every lane is served.
// Optional feature macro: RV32V_VMEM_COALESCE_EN -- when defined, every
// pending lane in the leader's block rides in the same transaction; when
// undefined each enabled lane gets its own transaction in lane order.
//
// Handshakes: a request transfers on a cycle with req_valid & req_ready,
// a response on a cycle with resp_valid & resp_ready; a bus transaction
// holds its strobe and payload stable and completes on the first strobe
// cycle with bus_busy low.
module rv32v_vmem_sequencer
  import rv32v_types_pkg::*;
#(
  parameter  int NUM_LANES   = NUM_LANES_DEF,
  parameter  int BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [1:0]                req_width,
  input  logic                      req_signed,
  input  logic [NUM_LANES-1:0]      req_mask,
  input  logic [NUM_LANES*32-1:0]   req_addr,
  input  logic [NUM_LANES*32-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_fault,
  output logic [LW-1:0]             resp_fault_lane,
  output logic [NUM_LANES*32-1:0]   resp_rdata,
  output logic                      bus_ren,
  output logic                      bus_wen,
  output logic [31:0]               bus_addr,
  output logic [BLOCK_WORDS*4-1:0]  bus_byte_en,
  output logic [BLOCK_WORDS*32-1:0] bus_wdata,
  input  logic [BLOCK_WORDS*32-1:0] bus_rdata,
  input  logic                      bus_busy,
  output vseq_state_e               dbg_state_o
);

  localparam int          OFFW     = $clog2(BLOCK_WORDS) + 2;
  localparam int          BYTES    = BLOCK_WORDS * 4;
  localparam logic [31:0] BLK_MASK = ~((32'd1 << OFFW) - 32'd1);
`ifdef RV32V_VMEM_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  vseq_state_e            state_q, state_d;
  logic [NUM_LANES-1:0]   pending_q, pending_d;
  logic                   store_q;
  vw_e                    width_q;
  logic                   signed_q;
  logic [31:0]            addr_q  [NUM_LANES];
  logic [31:0]            wdata_q [NUM_LANES];
  logic [31:0]            rdata_q [NUM_LANES];
  logic                   fault_q;
  logic [LW-1:0]          fault_lane_q;

  logic                   fault_any;
  logic [LW-1:0]          fault_idx;
  logic [LW-1:0]          lead_idx;
  logic [31:0]            lead_blk;
  logic [NUM_LANES-1:0]   grp;
  logic [BYTES-1:0]       merged_be;
  logic [BYTES*8-1:0]     merged_wd;
  logic [31:0]            lane_data [NUM_LANES];

  assign dbg_state_o = state_q;

  // Lowest enabled lane that breaks the alignment rule, if any.
  always_comb begin
    fault_any = 1'b0;
    fault_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_q[i] && lane_misaligned(width_q, addr_q[i][1:0])) begin
        fault_any = 1'b1;
        fault_idx = LW'(i);
      end
    end
  end

  // Leader lane, its block address and the lanes that share the transaction.
  always_comb begin
    lead_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) lead_idx = LW'(i);
    end
    lead_blk = addr_q[lead_idx] & BLK_MASK;
    grp      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (COALESCE) grp[i] = pending_q[i] && ((addr_q[i] & BLK_MASK) == lead_blk);
      else          grp[i] = pending_q[i] && (LW'(i) == lead_idx);
    end
  end

  // Byte enables and replicated store data; ascending lane order lets the
  // highest lane win when two group lanes hit the same byte.
  always_comb begin
    logic [OFFW-1:0] base;
    logic [OFFW-1:0] off;
    logic [31:0]     sh;
    int              nb;
    merged_be = '0;
    merged_wd = '0;
    base      = '0;
    off       = '0;
    sh        = '0;
    nb        = 4;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grp[i]) begin
        case (width_q)
          VW_BYTE: begin nb = 1; base = addr_q[i][OFFW-1:0]; end
          VW_HALF: begin nb = 2; base = {addr_q[i][OFFW-1:1], 1'b0}; end
          default: begin nb = 4; base = {addr_q[i][OFFW-1:2], 2'b00}; end
        endcase
        for (int k = 0; k < 4; k++) begin
          if (k < nb) begin
            off = base + OFFW'(k);
            sh  = wdata_q[i] >> (8 * k);
            merged_be[off] = 1'b1;
            merged_wd[{off, 3'b000} +: 8] = sh[7:0];
          end
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      rv32v_vmem_lane_extract #(.BLOCK_WORDS(BLOCK_WORDS)) u_extract (
        .blk_i    (bus_rdata),
        .addr_i   (addr_q[g][OFFW-1:0]),
        .width_i  (width_q),
        .signed_i (signed_q),
        .data_o   (lane_data[g])
      );
    end
  endgenerate

  // Next-state and handshake/strobe outputs.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bus_ren    = 1'b0;
    bus_wen    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d   = CHECK;
          pending_d = req_mask;
        end
      end
      CHECK: begin
        if (fault_any || pending_q == '0) state_d = RESP;
        else                              state_d = ISSUE;
      end
      ISSUE: begin
        bus_ren = ~store_q;
        bus_wen = store_q;
        if (!bus_busy) begin
          pending_d = pending_q & ~grp;
          if (pending_d == '0) state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_addr        = (state_q == ISSUE) ? lead_blk : '0;
  assign bus_byte_en     = (state_q == ISSUE) ? merged_be : '0;
  assign bus_wdata       = (state_q == ISSUE && store_q) ? merged_wd : '0;
  assign resp_fault      = resp_valid & fault_q;
  assign resp_fault_lane = resp_valid ? fault_lane_q : '0;

  // Flatten the latched per-lane results onto the response bus.
  always_comb begin
    resp_rdata = '0;
    for (int i = 0; i < NUM_LANES; i++) resp_rdata[i*32 +: 32] = rdata_q[i];
  end

  // State, latched request and captured results.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      store_q      <= 1'b0;
      width_q      <= VW_BYTE;
      signed_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_lane_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (state_q == IDLE && req_valid) begin
        store_q      <= req_store;
        width_q      <= vw_e'(req_width);
        signed_q     <= req_signed;
        fault_q      <= 1'b0;
        fault_lane_q <= '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          addr_q[i]  <= req_addr[i*32 +: 32];
          wdata_q[i] <= req_wdata[i*32 +: 32];
          rdata_q[i] <= '0;
        end
      end
      if (state_q == CHECK && fault_any) begin
        fault_q      <= 1'b1;
        fault_lane_q <= fault_idx;
      end
      if (state_q == ISSUE && !bus_busy && !store_q) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (grp[i]) rdata_q[i] <= lane_data[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32v_vmem_sequencer.sv
// Bench for rv32v_vmem_sequencer: directed cases plus randomized requests,
// checked against a transaction-level memory model.
module tb_rv32v_vmem_sequencer;
  import rv32v_types_pkg::*;

  localparam int NL = 4;
  localparam int BW = 4;
  localparam int BB = BW * 4;
`ifdef RV32V_VMEM_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic            req_valid = 1'b0, req_store = 1'b0, req_signed = 1'b0;
  logic [1:0]      req_width = 2'd0;
  logic [NL-1:0]   req_mask = '0;
  logic [NL*32-1:0] req_addr = '0, req_wdata = '0;
  logic            resp_ready = 1'b0;
  logic            req_ready, resp_valid, resp_fault;
  logic [1:0]      resp_fault_lane;
  logic [NL*32-1:0] resp_rdata;
  logic            bus_ren, bus_wen;
  logic [31:0]     bus_addr;
  logic [BB-1:0]   bus_byte_en;
  logic [BB*8-1:0] bus_wdata;
  logic [BB*8-1:0] bus_rdata = '0;
  logic            bus_busy = 1'b0;
  vseq_state_e     dbg_state;

  rv32v_vmem_sequencer #(.NUM_LANES(NL), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_width(req_width), .req_signed(req_signed), .req_mask(req_mask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_fault(resp_fault),
    .resp_fault_lane(resp_fault_lane), .resp_rdata(resp_rdata),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_busy(bus_busy), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]      mem [logic [31:0]];
  logic [31:0]     r_addr [NL];
  logic [31:0]     r_wdata [NL];

  logic [31:0]     log_addr [$];
  logic            log_wr [$];
  logic [BB-1:0]   log_be [$];
  logic [BB*8-1:0] log_wd [$];
  int              log_wait [$];

  logic [31:0]     exp_q [$];
  logic [BB-1:0]   exp_be_q [$];
  logic [BB*8-1:0] exp_wd_q [$];

  int force_wait = -1;
  bit hold_busy  = 1'b0;
  bit in_txn     = 1'b0;
  int wait_left  = 0;
  int cur_wait   = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus responder (memory behind the wide bus) ----------------
  always @(negedge CLK) begin
    if (bus_ren || bus_wen) begin
      if (!in_txn) begin
        in_txn    = 1'b1;
        cur_wait  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
        wait_left = cur_wait;
      end
      if (hold_busy || wait_left > 0) begin
        bus_busy = 1'b1;
        if (wait_left > 0) wait_left--;
      end else begin
        bus_busy = 1'b0;
        for (int j = 0; j < BB; j++) bus_rdata[j*8 +: 8] = rd_byte(bus_addr + 32'(j));
        log_addr.push_back(bus_addr);
        log_wr.push_back(bus_wen);
        log_be.push_back(bus_byte_en);
        log_wd.push_back(bus_wdata);
        log_wait.push_back(cur_wait);
        if (bus_wen)
          for (int j = 0; j < BB; j++)
            if (bus_byte_en[j]) mem[bus_addr + 32'(j)] = bus_wdata[j*8 +: 8];
        in_txn = 1'b0;
      end
    end else begin
      bus_busy = 1'b0;
      in_txn   = 1'b0;
    end
  end

  // ---------------- driver + reference model for one request ----------------
  task automatic run_req(input string tag, input logic st, input logic [1:0] w,
                         input logic sg, input logic [NL-1:0] m);
    int               nb, n, exp_lat;
    logic             exp_fault;
    logic [1:0]       exp_lane;
    logic [NL-1:0]    done;
    logic [31:0]      blk, v;
    logic [BB-1:0]    be;
    logic [BB*8-1:0]  wd, msk;
    logic [NL*32-1:0] exp_rdata;
    int               off;

    nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    exp_fault = 1'b0;
    exp_lane  = '0;
    for (int i = 0; i < NL; i++)
      if (m[i] && !exp_fault &&
          ((w == 2'd1 && r_addr[i][0]) || (w == 2'd2 && r_addr[i][1:0] != 2'b00))) begin
        exp_fault = 1'b1;
        exp_lane  = 2'(i);
      end

    // expected transactions: one per distinct block (coalesced) or per lane
    exp_q.delete(); exp_be_q.delete(); exp_wd_q.delete();
    done = '0;
    if (!exp_fault)
      for (int i = 0; i < NL; i++)
        if (m[i] && !done[i]) begin
          blk = r_addr[i] & ~32'(BB - 1);
          be = '0; wd = '0;
          for (int j = i; j < NL; j++)
            if (m[j] && !done[j] &&
                (COAL ? ((r_addr[j] & ~32'(BB - 1)) == blk) : (j == i))) begin
              done[j] = 1'b1;
              for (int k = 0; k < nb; k++) begin
                off = int'(r_addr[j] & 32'(BB - 1)) + k;
                be[off] = 1'b1;
                wd[off*8 +: 8] = 8'(r_wdata[j] >> (8 * k));
              end
            end
          exp_q.push_back(blk);
          exp_be_q.push_back(be);
          exp_wd_q.push_back(wd);
        end

    // expected load results from the memory image
    exp_rdata = '0;
    if (!st && !exp_fault)
      for (int i = 0; i < NL; i++)
        if (m[i]) begin
          v = '0;
          for (int k = 0; k < nb; k++) v = v | (32'(rd_byte(r_addr[i] + 32'(k))) << (8 * k));
          if (nb == 1)      v = {{24{sg & v[7]}}, v[7:0]};
          else if (nb == 2) v = {{16{sg & v[15]}}, v[15:0]};
          exp_rdata[i*32 +: 32] = v;
        end

    // drive the request
    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    chk({tag, " req_ready before"}, 128'(req_ready), 128'(1));
    log_addr.delete(); log_wr.delete(); log_be.delete(); log_wd.delete(); log_wait.delete();
    req_store = st; req_width = w; req_signed = sg; req_mask = m;
    for (int i = 0; i < NL; i++) begin
      req_addr[i*32 +: 32]  = r_addr[i];
      req_wdata[i*32 +: 32] = r_wdata[i];
    end
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    n = 1;
    chk({tag, " req_ready busy"}, 128'(req_ready), 128'(0));
    while (!resp_valid && n < 300) begin @(negedge CLK); n++; end
    if (!resp_valid) begin
      chk({tag, " resp timeout"}, 128'(resp_valid), 128'(1));
      return;
    end

    exp_lat = 2;
    if (!exp_fault) foreach (log_wait[i]) exp_lat += log_wait[i] + 1;
    chk({tag, " latency"}, 128'(n), 128'(exp_lat));
    chk({tag, " fault"}, 128'(resp_fault), 128'(exp_fault));
    if (exp_fault) chk({tag, " fault lane"}, 128'(resp_fault_lane), 128'(exp_lane));
    chk({tag, " txn count"}, 128'(log_addr.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
      chk($sformatf("%s txn%0d addr", tag, i), 128'(log_addr[i]), 128'(exp_q[i]));
      chk($sformatf("%s txn%0d dir", tag, i), 128'(log_wr[i]), 128'(st));
      if (st) begin
        msk = '0;
        for (int j = 0; j < BB; j++) if (exp_be_q[i][j]) msk[j*8 +: 8] = 8'hFF;
        chk($sformatf("%s txn%0d byte_en", tag, i), 128'(log_be[i]), 128'(exp_be_q[i]));
        chk($sformatf("%s txn%0d wdata", tag, i), 128'(log_wd[i] & msk), 128'(exp_wd_q[i]));
      end
    end
    if (!st && !exp_fault) chk({tag, " rdata"}, 128'(resp_rdata), 128'(exp_rdata));
    chk({tag, " req_ready in resp"}, 128'(req_ready), 128'(0));

    // hold the response for a while, then accept it
    n = int'($urandom_range(0, 3));
    for (int h = 0; h < n; h++) begin
      @(negedge CLK);
      chk({tag, " resp held"}, 128'(resp_valid), 128'(1));
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    chk({tag, " resp drop"}, 128'(resp_valid), 128'(0));
    chk({tag, " ready after"}, 128'(req_ready), 128'(1));
  endtask

  // ---------------- directed steps + random requests ----------------
  initial begin
    int nb, n;
    logic [31:0] blks [4];
    blks[0] = 32'h1000; blks[1] = 32'h1010; blks[2] = 32'h1020; blks[3] = 32'h2000;

    #12;
    chk("reset req_ready", 128'(req_ready), 128'(1));
    chk("reset resp_valid", 128'(resp_valid), 128'(0));
    chk("reset strobes", 128'({bus_ren, bus_wen}), 128'(0));
    chk("reset bus_addr", 128'(bus_addr), 128'(0));
    @(negedge CLK);
    nRST = 1'b1;

    // four word loads in one block, busy 2 cycles
    for (int i = 0; i < NL; i++) begin r_addr[i] = 32'h100 + 32'(4 * i); r_wdata[i] = '0; end
    force_wait = 2;
    run_req("word4", 1'b0, 2'd2, 1'b0, 4'b1111);
    force_wait = -1;

    // signed byte loads across two blocks
    mem[32'h203] = 8'h80; mem[32'h400] = 8'h7F;
    r_addr[0] = 32'h203; r_addr[1] = 32'h400; r_addr[2] = 32'h0; r_addr[3] = 32'h0;
    run_req("sbyte", 1'b0, 2'd0, 1'b1, 4'b0011);

    // half load with misaligned enabled lane 2; masked lane 0 also misaligned
    r_addr[0] = 32'h301; r_addr[1] = 32'h302; r_addr[2] = 32'h301; r_addr[3] = 32'h303;
    run_req("halffault", 1'b0, 2'd1, 1'b0, 4'b0110);

    // empty mask
    run_req("empty", 1'b0, 2'd2, 1'b0, 4'b0000);

    // byte stores colliding on one byte
    r_addr[0] = 32'h500; r_addr[3] = 32'h500; r_addr[1] = 32'h0; r_addr[2] = 32'h0;
    r_wdata[0] = 32'hAA; r_wdata[3] = 32'hBB; r_wdata[1] = '0; r_wdata[2] = '0;
    run_req("bytest", 1'b1, 2'd0, 1'b0, 4'b1001);
    chk("bytest mem", 128'(rd_byte(32'h500)), 128'(8'hBB));

    // randomized requests
    for (int t = 0; t < 24; t++) begin
      logic [1:0] w;
      w  = 2'($urandom_range(0, 2));
      nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      for (int i = 0; i < NL; i++) begin
        r_addr[i] = blks[$urandom_range(0, 3)] + 32'($urandom_range(0, BB - 1));
        if ($urandom_range(0, 7) != 0) r_addr[i] = r_addr[i] & ~32'(nb - 1);
        r_wdata[i] = $urandom;
      end
      run_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), w,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // reset while a strobe is held
    hold_busy = 1'b1;
    r_addr[0] = 32'h600;
    @(negedge CLK);
    req_store = 1'b0; req_width = 2'd2; req_mask = 4'b0001;
    req_addr[31:0] = r_addr[0];
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    n = 0;
    while (!bus_ren && n < 20) begin @(negedge CLK); n++; end
    chk("rst strobe up", 128'(bus_ren), 128'(1));
    #2 nRST = 1'b0;
    #1;
    chk("rst strobe drop", 128'({bus_ren, bus_wen}), 128'(0));
    chk("rst req_ready", 128'(req_ready), 128'(1));
    chk("rst resp_valid", 128'(resp_valid), 128'(0));
    hold_busy = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post rst idle", 128'({req_ready, resp_valid, bus_ren}), 128'(3'b100));

    // sequencer still works after reset
    for (int i = 0; i < NL; i++) begin r_addr[i] = 32'h700 + 32'(8 * i); r_wdata[i] = '0; end
    run_req("postrst", 1'b0, 2'd1, 1'b1, 4'b1011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
